// File: rtl/oet_stream_sorter_pkg.sv
// Shared definitions for the odd-even transposition stream sorter:
// FSM state encoding and the block geometry derived from the log2 parameters.
package oet_stream_sorter_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   function automatic int calc_n(input int p_log);
      return 1 << p_log;
   endfunction

   function automatic int calc_l(input int l_log);
      return 1 << l_log;
   endfunction

   function automatic int calc_beats(input int p_log, input int l_log);
      return 1 << (p_log - l_log);
   endfunction

   localparam int DEF_P_LOG = 4;
   localparam int DEF_L_LOG = 2;
   localparam int N         = calc_n(DEF_P_LOG);
   localparam int L         = calc_l(DEF_L_LOG);
   localparam int BEATS     = calc_beats(DEF_P_LOG, DEF_L_LOG);

endpackage

// File: rtl/oet_cas.sv
// Combinational compare-exchange of two adjacent records on their low KEYW bits.
// Equal keys never swap, which keeps the overall sort stable.
module oet_cas #(
   parameter int DATW = 64,
   parameter int KEYW = 32
) (
   input  logic            dir,
   input  logic [DATW-1:0] a,
   input  logic [DATW-1:0] b,
   output logic [DATW-1:0] x,
   output logic [DATW-1:0] y
);

   logic swap;

   assign swap = dir ? (a[KEYW-1:0] < b[KEYW-1:0])
                     : (a[KEYW-1:0] > b[KEYW-1:0]);
   assign x    = swap ? b : a;
   assign y    = swap ? a : b;

endmodule

// File: rtl/oet_stream_sorter.sv
// Block sorter: loads N records in beats of L, runs N odd-even transposition
// passes in place, then streams the block out with valid/ready back-pressure.
module oet_stream_sorter
   import oet_stream_sorter_pkg::*;
#(
   parameter int P_LOG = 4,
   parameter int L_LOG = 2,
   parameter int DATW  = 64,
   parameter int KEYW  = 32
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [DATW*(1<<L_LOG)-1:0] DIN,
   input  logic                       DINEN,
   input  logic                       DIR,
   output logic                       DIN_RDY,
   output logic [DATW*(1<<L_LOG)-1:0] DOT,
   output logic                       DOTEN,
   input  logic                       DOT_RDY,
   output state_t                     state
);

   // Handshake: a beat moves on a rising edge only when its valid and ready are
   // both high; ready never depends on the same-side valid, and a stalled DOT holds.
   localparam int NR  = calc_n(P_LOG);
   localparam int LR  = calc_l(L_LOG);
   localparam int NB  = calc_beats(P_LOG, L_LOG);
   localparam int BW  = (P_LOG > L_LOG) ? (P_LOG - L_LOG) : 1;
   localparam int PW  = P_LOG;

   state_t          state_q, state_d;
   logic [BW-1:0]   in_cnt, out_cnt;
   logic [PW-1:0]   pass_cnt;
   logic            dir_q;
   logic [DATW-1:0] buf_q  [NR];
   logic [DATW-1:0] pass_d [NR];
   logic [DATW-1:0] cas_x  [NR-1];
   logic [DATW-1:0] cas_y  [NR-1];
   logic            in_fire, out_fire, in_last, out_last, pass_last, odd_pass;

   assign state     = state_q;
   assign in_fire   = DIN_RDY & DINEN;
   assign out_fire  = DOTEN & DOT_RDY;
   assign in_last   = (in_cnt == BW'(NB - 1));
   assign out_last  = (out_cnt == BW'(NB - 1));
   assign pass_last = (pass_cnt == PW'(NR - 1));
   assign odd_pass  = pass_cnt[0];

   always_ff @(posedge CLK) begin
      if (RST) state_q <= LOAD;
      else     state_q <= state_d;
   end

   // Flags are gated by RST so nothing is offered or accepted while reset is held.
   always_comb begin
      state_d = state_q;
      DIN_RDY = 1'b0;
      DOTEN   = 1'b0;
      case (state_q)
         LOAD: begin
            DIN_RDY = ~RST;
            if (in_fire && in_last) state_d = SORT;
         end
         SORT: begin
            if (pass_last) state_d = DRAIN;
         end
         DRAIN: begin
            DOTEN = ~RST;
            if (out_fire && out_last) state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         in_cnt   <= '0;
         out_cnt  <= '0;
         pass_cnt <= '0;
         dir_q    <= 1'b0;
      end else begin
         if (in_fire) begin
            in_cnt <= in_last ? '0 : in_cnt + 1'b1;
            if (in_cnt == '0) dir_q <= DIR;
         end
         if (in_fire && in_last)     pass_cnt <= '0;
         else if (state_q == SORT)   pass_cnt <= pass_last ? '0 : pass_cnt + 1'b1;
         if (out_fire) out_cnt <= out_last ? '0 : out_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < NR - 1; i++) begin : g_cas
      oet_cas #(
         .DATW (DATW),
         .KEYW (KEYW)
      ) u_cas (
         .dir (dir_q),
         .a   (buf_q[i]),
         .b   (buf_q[i+1]),
         .x   (cas_x[i]),
         .y   (cas_y[i])
      );
   end

   // Each interior slot belongs to exactly one active pair per pass: pair (k,k+1)
   // when k's parity matches the pass, otherwise pair (k-1,k). End slots idle on odd passes.
   for (genvar k = 0; k < NR; k++) begin : g_slot
      if (k == 0) begin : g_first
         assign pass_d[k] = odd_pass ? buf_q[k] : cas_x[k];
      end else if (k == NR - 1) begin : g_last
         assign pass_d[k] = odd_pass ? buf_q[k] : cas_y[k-1];
      end else if ((k % 2) == 1) begin : g_odd
         assign pass_d[k] = odd_pass ? cas_x[k] : cas_y[k-1];
      end else begin : g_even
         assign pass_d[k] = odd_pass ? cas_y[k-1] : cas_x[k];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < NR; k++) buf_q[k] <= '0;
      end else if (in_fire) begin
         for (int b = 0; b < NB; b++) begin
            if (in_cnt == BW'(b)) begin
               for (int j = 0; j < LR; j++) buf_q[b*LR + j] <= DIN[DATW*j +: DATW];
            end
         end
      end else if (state_q == SORT) begin
         for (int k = 0; k < NR; k++) buf_q[k] <= pass_d[k];
      end
   end

   always_comb begin
      DOT = '0;
      for (int b = 0; b < NB; b++) begin
         if (out_cnt == BW'(b)) begin
            for (int j = 0; j < LR; j++) DOT[DATW*j +: DATW] = buf_q[b*LR + j];
         end
      end
   end

endmodule

// File: tb/tb_oet_stream_sorter.sv
// Bench for oet_stream_sorter: a 16-record/4-lane instance and an 8-record/8-lane
// instance, each checked against a rank-based stable-sort model.
module tb_oet_stream_sorter;
   import oet_stream_sorter_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [255:0] a_din, a_dot;
   logic         a_dinen, a_dir, a_din_rdy, a_doten, a_dot_rdy;
   state_t       a_state;
   logic [511:0] b_din, b_dot;
   logic         b_dinen, b_dir, b_din_rdy, b_doten, b_dot_rdy;
   state_t       b_state;

   oet_stream_sorter #(.P_LOG(4), .L_LOG(2), .DATW(64), .KEYW(32)) dut_a (
      .CLK(clk), .RST(rst), .DIN(a_din), .DINEN(a_dinen), .DIR(a_dir),
      .DIN_RDY(a_din_rdy), .DOT(a_dot), .DOTEN(a_doten), .DOT_RDY(a_dot_rdy),
      .state(a_state)
   );

   oet_stream_sorter #(.P_LOG(3), .L_LOG(3), .DATW(64), .KEYW(32)) dut_b (
      .CLK(clk), .RST(rst), .DIN(b_din), .DINEN(b_dinen), .DIR(b_dir),
      .DIN_RDY(b_din_rdy), .DOT(b_dot), .DOTEN(b_doten), .DOT_RDY(b_dot_rdy),
      .state(b_state)
   );

   int           checks = 0;
   int           errors = 0;
   logic [63:0]  blk [16];
   logic [511:0] exp_q [$];

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [511:0] rand_beat();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic get_rdy(input int sel);
      return (sel != 0) ? b_din_rdy : a_din_rdy;
   endfunction

   function automatic logic get_doten(input int sel);
      return (sel != 0) ? b_doten : a_doten;
   endfunction

   function automatic logic [511:0] get_dot(input int sel);
      return (sel != 0) ? b_dot : 512'(a_dot);
   endfunction

   task automatic drive(input int sel, input logic [511:0] d, input logic en, input logic dr);
      if (sel != 0) begin
         b_din = d; b_dinen = en; b_dir = dr;
      end else begin
         a_din = d[255:0]; a_dinen = en; a_dir = dr;
      end
   endtask

   task automatic set_dot_rdy(input int sel, input logic r);
      if (sel != 0) b_dot_rdy = r;
      else          a_dot_rdy = r;
   endtask

   // Stable sort by rank: a record's slot is the number of records that must
   // precede it (strictly better key, or equal key with a lower input index).
   task automatic build_expected(input int n, input int l, input logic dr);
      logic [63:0]  sorted [16];
      logic [511:0] beat;
      int           rank;
      for (int i = 0; i < n; i++) begin
         rank = 0;
         for (int j = 0; j < n; j++) begin
            if (dr ? (blk[j][31:0] > blk[i][31:0]) : (blk[j][31:0] < blk[i][31:0])) rank++;
            else if (blk[j][31:0] == blk[i][31:0] && j < i) rank++;
         end
         sorted[rank] = blk[i];
      end
      for (int b = 0; b < n / l; b++) begin
         beat = '0;
         for (int j = 0; j < l; j++) beat[64*j +: 64] = sorted[b*l + j];
         exp_q.push_back(beat);
      end
   endtask

   task automatic load_block(input int sel, input logic dr, input bit gaps);
      int           n = (sel != 0) ? 8 : 16;
      int           l = (sel != 0) ? 8 : 4;
      int           w = 0;
      logic [511:0] beat;
      while (get_rdy(sel) !== 1'b1 && w < 64) begin
         tick();
         w++;
      end
      check("din_rdy_before_load", 512'(get_rdy(sel)), 512'(1'b1));
      build_expected(n, l, dr);
      for (int k = 0; k < n / l; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               drive(sel, rand_beat(), 1'b0, ~dr);
               tick();
            end
         end
         beat = '0;
         for (int j = 0; j < l; j++) beat[64*j +: 64] = blk[k*l + j];
         drive(sel, beat, 1'b1, (k == 0) ? dr : ~dr);
         tick();
      end
      drive(sel, '0, 1'b0, 1'b0);
   endtask

   // Output must stay quiet for exactly N cycles after the last input edge,
   // while DINEN/DOT_RDY toggle with junk that has to be ignored.
   task automatic sort_phase(input int sel);
      int n = (sel != 0) ? 8 : 16;
      for (int c = 0; c < n; c++) begin
         check("quiet_during_sort", 512'({get_doten(sel), get_rdy(sel)}), 512'(2'b00));
         drive(sel, rand_beat(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         set_dot_rdy(sel, 1'($urandom_range(0, 1)));
         tick();
      end
      drive(sel, '0, 1'b0, 1'b0);
   endtask

   task automatic drain_block(input int sel, input bit rand_rdy);
      int           nb = (sel != 0) ? 1 : 4;
      int           stalls;
      logic         r;
      logic [511:0] e;
      for (int b = 0; b < nb; b++) begin
         e      = exp_q.pop_front();
         stalls = 0;
         r      = 1'b0;
         while (!r) begin
            r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalls >= 6) r = 1'b1;
            set_dot_rdy(sel, r);
            drive(sel, rand_beat(), 1'($urandom_range(0, 1)), 1'b0);
            check("drain_flags", 512'({get_doten(sel), get_rdy(sel)}), 512'(2'b10));
            check("dot_beat", get_dot(sel), e);
            tick();
            stalls++;
         end
      end
      set_dot_rdy(sel, 1'b0);
      drive(sel, '0, 1'b0, 1'b0);
      check("bubble_then_ready", 512'({get_doten(sel), get_rdy(sel)}), 512'(2'b01));
   endtask

   task automatic run_block(input int sel, input logic dr, input bit gaps, input bit rand_rdy);
      load_block(sel, dr, gaps);
      sort_phase(sel);
      drain_block(sel, rand_rdy);
   endtask

   initial begin
      logic [31:0] fixed_keys [16];
      logic        dr;
      fixed_keys = '{32'd8, 32'd3, 32'd1, 32'd15, 32'd0, 32'd7, 32'd12, 32'd4,
                     32'd9, 32'd2, 32'd14, 32'd6, 32'd11, 32'd5, 32'd13, 32'd10};
      rst = 1'b1;
      a_din = '0; a_dinen = 1'b0; a_dir = 1'b0; a_dot_rdy = 1'b0;
      b_din = '0; b_dinen = 1'b0; b_dir = 1'b0; b_dot_rdy = 1'b0;
      repeat (3) tick();
      check("rst_a_flags", 512'({a_doten, a_din_rdy}), 512'(2'b00));
      check("rst_a_dot", 512'(a_dot), 512'(0));
      check("rst_a_state", 512'(a_state), 512'(LOAD));
      check("rst_b_flags", 512'({b_doten, b_din_rdy}), 512'(2'b00));
      rst = 1'b0;
      tick();
      check("a_rdy_after_rst", 512'(a_din_rdy), 512'(1'b1));
      check("b_rdy_after_rst", 512'(b_din_rdy), 512'(1'b1));

      // Descending keys sorted ascending
      for (int i = 0; i < 16; i++) blk[i] = {$urandom, 32'(16 - i)};
      run_block(0, 1'b0, 1'b0, 1'b0);

      // Ascending keys sorted descending, upper bits carried along
      for (int i = 0; i < 16; i++) blk[i] = {$urandom, 32'(i + 1)};
      run_block(0, 1'b1, 1'b0, 1'b0);

      // All-equal keys keep input order in both directions
      for (int i = 0; i < 16; i++) blk[i] = {32'(i), 32'd5};
      run_block(0, 1'b0, 1'b0, 1'b0);
      run_block(0, 1'b1, 1'b0, 1'b0);

      // Random keys (with duplicates), input gaps and output stalls
      for (int t = 0; t < 4; t++) begin
         dr = 1'($urandom_range(0, 1));
         for (int i = 0; i < 16; i++)
            blk[i] = {$urandom, (t % 2 == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom)};
         run_block(0, dr, 1'b1, 1'b1);
      end

      // Reset in the middle of SORT abandons the block
      for (int i = 0; i < 16; i++) blk[i] = {$urandom, $urandom};
      load_block(0, 1'b0, 1'b0);
      exp_q.delete();
      repeat (7) tick();
      check("pre_rst_sort_state", 512'(a_state), 512'(SORT));
      rst = 1'b1;
      tick();
      check("mid_rst_flags", 512'({a_doten, a_din_rdy}), 512'(2'b00));
      check("mid_rst_dot", 512'(a_dot), 512'(0));
      check("mid_rst_state", 512'(a_state), 512'(LOAD));
      tick();
      check("mid_rst_flags_hold", 512'({a_doten, a_din_rdy}), 512'(2'b00));
      rst = 1'b0;
      tick();
      check("post_rst_flags", 512'({a_doten, a_din_rdy}), 512'(2'b01));
      check("post_rst_dot", 512'(a_dot), 512'(0));
      for (int i = 0; i < 16; i++) blk[i] = {32'(100 + i), fixed_keys[i]};
      run_block(0, 1'b0, 1'b0, 1'b0);

      // Single-beat blocks, four back to back
      for (int t = 0; t < 4; t++) begin
         dr = 1'($urandom_range(0, 1));
         for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom};
         run_block(1, dr, 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
